// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, opcode and ALU encodings, and the
// decoded instruction packet handed from IF to ID.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add,
    alu_and,
    alu_not,
    alu_pass,
    alu_sll,
    alu_srl,
    alu_sra
  } lc3b_aluop;

  typedef struct packed {
    lc3b_opcode opcode;
    lc3b_word   pc;
    lc3b_word   inst;
    logic [2:0] dr_sr;
    logic [2:0] nzp;
    logic [2:0] sr1;
    logic [2:0] sr2;
    lc3b_aluop  aluop;
    logic       alumux_sel;
    logic       load_cc;
    logic       cc_mux_sel;
    logic       load_regfile;
    logic [1:0] pcmux_sel;
    logic       regfile_mux_sel;
    logic       byte_op;
    logic       mem_read;
    logic       mem_write;
    logic       sr2_mux_sel;
    logic       wdatamux_sel;
  } lc3b_ipacket;

endpackage

// File: rtl/ipacket_decoder.sv
// Combinational LC-3b decode table: instruction word and PC in, control
// packet and illegal-opcode flag out. RTI is optionally trapped to a NOP.
module ipacket_decoder
  import lc3b_types::*;
#(
  parameter bit FLAG_ILLEGAL = 1'b1
) (
  input  lc3b_word    inst,
  input  lc3b_word    pc,
  output lc3b_ipacket ipacket,
  output logic        illegal
);

  // Build the default packet, then apply the per-opcode overrides.
  always_comb begin
    // NOTE: every output gets a value before the case so no path can leave it unassigned and infer a latch.
    ipacket        = '0;
    illegal        = 1'b0;
    ipacket.opcode = lc3b_opcode'(inst[15:12]);
    ipacket.pc     = pc;
    ipacket.inst   = inst;
    ipacket.dr_sr  = inst[11:9];
    ipacket.nzp    = inst[11:9];
    ipacket.sr1    = inst[8:6];
    ipacket.sr2    = inst[2:0];
    ipacket.aluop  = alu_pass;

    unique case (lc3b_opcode'(inst[15:12]))
      op_add, op_and: begin
        ipacket.aluop        = (inst[15:12] == op_add) ? alu_add : alu_and;
        ipacket.alumux_sel   = inst[5];
        ipacket.load_cc      = 1'b1;
        ipacket.cc_mux_sel   = 1'b1;
        ipacket.load_regfile = 1'b1;
      end
      op_not: begin
        ipacket.aluop        = alu_not;
        ipacket.load_cc      = 1'b1;
        ipacket.cc_mux_sel   = 1'b1;
        ipacket.load_regfile = 1'b1;
      end
      op_shf: begin
        ipacket.load_cc      = 1'b1;
        ipacket.cc_mux_sel   = 1'b1;
        ipacket.load_regfile = 1'b1;
        if (!inst[4])     ipacket.aluop = alu_sll;
        else if (!inst[5]) ipacket.aluop = alu_srl;
        else              ipacket.aluop = alu_sra;
      end
      op_br: ipacket.pcmux_sel = 2'b10;
      op_jmp: begin
        ipacket.pcmux_sel  = 2'b01;
        ipacket.alumux_sel = 1'b1;
      end
      op_jsr: begin
        ipacket.load_regfile    = 1'b1;
        ipacket.dr_sr           = 3'b111;
        ipacket.regfile_mux_sel = 1'b1;
        ipacket.pcmux_sel       = inst[11] ? 2'b10 : 2'b01;
      end
      op_ldb, op_ldr, op_ldi: begin
        ipacket.byte_op      = (inst[15:12] == op_ldb);
        ipacket.aluop        = alu_add;
        ipacket.alumux_sel   = 1'b1;
        ipacket.mem_read     = 1'b1;
        ipacket.load_regfile = 1'b1;
        ipacket.load_cc      = 1'b1;
      end
      op_lea: begin
        ipacket.load_regfile = 1'b1;
        ipacket.wdatamux_sel = 1'b1;
        ipacket.load_cc      = 1'b1;
        ipacket.cc_mux_sel   = 1'b1;
      end
      op_stb, op_str, op_sti: begin
        ipacket.byte_op     = (inst[15:12] == op_stb);
        ipacket.aluop       = alu_add;
        ipacket.alumux_sel  = 1'b1;
        ipacket.mem_write   = 1'b1;
        ipacket.sr2_mux_sel = 1'b1;
      end
      op_trap: begin
        ipacket.load_regfile    = 1'b1;
        ipacket.dr_sr           = 3'b111;
        ipacket.regfile_mux_sel = 1'b1;
        ipacket.mem_read        = 1'b1;
      end
      op_rti: begin
        // Trapped RTI keeps only its identity fields; every control is zero.
        if (FLAG_ILLEGAL) begin
          ipacket        = '0;
          ipacket.opcode = op_rti;
          ipacket.pc     = pc;
          ipacket.inst   = inst;
          illegal        = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ipacket_decode_queue.sv
// IF->ID decode queue: instructions are decoded on the way in and the
// resulting packets held in a DEPTH-entry FIFO. Flush empties it at once.
module ipacket_decode_queue
  import lc3b_types::*;
#(
  parameter int DEPTH        = 4,
  parameter bit FLAG_ILLEGAL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  lc3b_word                   in_inst,
  input  lc3b_word                   in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output lc3b_ipacket                out_ipacket,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  lc3b_ipacket   pkt_mem [DEPTH];
  logic [DEPTH-1:0] ill_mem;
  lc3b_ipacket   dec_pkt;
  logic          dec_ill;
  logic          enq;
  logic          deq;

  ipacket_decoder #(
    .FLAG_ILLEGAL(FLAG_ILLEGAL)
  ) u_decoder (
    .inst   (in_inst),
    .pc     (in_pc),
    .ipacket(dec_pkt),
    .illegal(dec_ill)
  );

  // Handshake: ready comes from the registered count only, never from out_ready.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  // Head view; forced to zero when empty so stale storage never shows.
  assign out_ipacket = out_valid ? pkt_mem[rd_ptr] : '0;
  assign out_illegal = out_valid & ill_mem[rd_ptr];

  // Storage write of the decoded packet at enqueue.
  // NOTE: storage has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      pkt_mem[wr_ptr] <= dec_pkt;
      ill_mem[wr_ptr] <= dec_ill;
    end
  end

  // Pointer and occupancy update; flush overrides any enqueue or dequeue.
  // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
